// File: rtl/dog_extrema_detector.sv
// Scale-space extremum detector for three raster-ordered DoG streams.
// Each DoG2 sample is compared against its 26 neighbours in a 3x3x3 window;
// strict local maxima/minima beyond the contrast threshold are flagged as
// keypoint candidates. Results emerge two cycles after the accepting sample.
module dog_extrema_detector #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int CONTRAST_TH = 3,
  parameter int XW          = $clog2(IMG_WIDTH),
  parameter int YW          = $clog2(IMG_HEIGHT)
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic                iValid,
  input  logic                iSOF,
  input  logic signed [8:0]   iDOG1,
  input  logic signed [8:0]   iDOG2,
  input  logic signed [8:0]   iDOG3,
  output logic                oValid,
  output logic                oKeypoint,
  output logic                oPolarity,
  output logic [XW-1:0]       oX,
  output logic [YW-1:0]       oY,
  output logic signed [8:0]   oDOG
);

  localparam logic [XW-1:0]      X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]      Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic signed [9:0]  TH_POS = 10'(CONTRAST_TH);
  localparam logic signed [9:0]  TH_NEG = -TH_POS;

  // position of the sample being accepted; iSOF overrides the counters
  logic [XW-1:0] xCnt, xCur;
  logic [YW-1:0] yCnt, yCur;
  logic          sofHit;

  // scale index 0 = DoG1, 1 = DoG2, 2 = DoG3; row 0 = oldest line
  logic signed [8:0] sample [3];
  logic signed [8:0] lineA  [3][IMG_WIDTH];   // row y-1
  logic signed [8:0] lineB  [3][IMG_WIDTH];   // row y-2
  logic signed [8:0] hist   [3][3][2];        // columns x-2, x-1
  logic signed [8:0] win    [3][3][3];        // full window incl. column x

  logic signed [8:0] centre;
  logic lowGt, lowLt, highGt, highLt, ringGt, ringLt;

  logic              s1Valid;
  logic [XW-1:0]     s1X;
  logic [YW-1:0]     s1Y;
  logic signed [8:0] s1Dog;
  logic              s1Border;
  logic              s1LowGt, s1LowLt, s1HighGt, s1HighLt, s1RingGt, s1RingLt;

  logic signed [9:0] cExt;
  logic              isMax, isMin;

  // effective coordinate of the incoming sample
  always_comb begin
    sofHit = iValid & iSOF;
    xCur   = sofHit ? '0 : xCnt;
    yCur   = sofHit ? '0 : yCnt;
  end

  // raster counters advance on every accepted sample
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (iValid) begin
      if (xCur == X_LAST) begin
        xCnt <= '0;
        yCnt <= (yCur == Y_LAST) ? '0 : yCur + YW'(1);
      end else begin
        xCnt <= xCur + XW'(1);
        yCnt <= yCur;
      end
    end
  end

  // assemble the 3x3x3 window from history columns plus the new column
  always_comb begin
    sample[0] = iDOG1;
    sample[1] = iDOG2;
    sample[2] = iDOG3;
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 3; r++) begin
        win[s][r][0] = hist[s][r][0];
        win[s][r][1] = hist[s][r][1];
      end
      win[s][0][2] = lineB[s][xCur];
      win[s][1][2] = lineA[s][xCur];
      win[s][2][2] = sample[s];
    end
  end

  // line buffers and window history; contents deliberately not reset,
  // stale data is only ever seen by border-suppressed windows
  always_ff @(posedge iclk) begin
    if (irst_n && iValid) begin
      for (int s = 0; s < 3; s++) begin
        lineA[s][xCur] <= sample[s];
        lineB[s][xCur] <= lineA[s][xCur];
        for (int r = 0; r < 3; r++) begin
          hist[s][r][0] <= hist[s][r][1];
          hist[s][r][1] <= win[s][r][2];
        end
      end
    end
  end

  // per-plane strict comparisons of the centre against its neighbours
  always_comb begin
    centre = win[1][1][1];
    lowGt  = 1'b1;
    lowLt  = 1'b1;
    highGt = 1'b1;
    highLt = 1'b1;
    ringGt = 1'b1;
    ringLt = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(centre > win[0][r][c])) lowGt  = 1'b0;
        if (!(centre < win[0][r][c])) lowLt  = 1'b0;
        if (!(centre > win[2][r][c])) highGt = 1'b0;
        if (!(centre < win[2][r][c])) highLt = 1'b0;
        if (!(r == 1 && c == 1)) begin
          if (!(centre > win[1][r][c])) ringGt = 1'b0;
          if (!(centre < win[1][r][c])) ringLt = 1'b0;
        end
      end
    end
  end

  // stage 1 valid: a result exists once both a prior row and column exist
  always_ff @(posedge iclk) begin
    if (!irst_n) s1Valid <= 1'b0;
    else         s1Valid <= iValid && (xCur != '0) && (yCur != '0);
  end

  // stage 1 payload: centre coordinate, value and partial compare results
  always_ff @(posedge iclk) begin
    if (iValid) begin
      s1X      <= xCur - XW'(1);
      s1Y      <= yCur - YW'(1);
      s1Dog    <= centre;
      s1Border <= (xCur == XW'(1)) || (yCur == YW'(1));
      s1LowGt  <= lowGt;
      s1LowLt  <= lowLt;
      s1HighGt <= highGt;
      s1HighLt <= highLt;
      s1RingGt <= ringGt;
      s1RingLt <= ringLt;
    end
  end

  // stage 2 decision: all planes agree and contrast clears the threshold
  always_comb begin
    cExt  = {s1Dog[8], s1Dog};
    isMax = !s1Border && s1LowGt && s1HighGt && s1RingGt && (cExt > TH_POS);
    isMin = !s1Border && s1LowLt && s1HighLt && s1RingLt && (cExt < TH_NEG);
  end

  // output register; fields hold while idle, flags drop to 0
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      oValid    <= 1'b0;
      oKeypoint <= 1'b0;
      oPolarity <= 1'b0;
      oX        <= '0;
      oY        <= '0;
      oDOG      <= '0;
    end else begin
      oValid <= s1Valid;
      if (s1Valid) begin
        oKeypoint <= isMax | isMin;
        oPolarity <= isMax;
        oX        <= s1X;
        oY        <= s1Y;
        oDOG      <= s1Dog;
      end else begin
        oKeypoint <= 1'b0;
        oPolarity <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dog_extrema_detector.sv
// Bench for dog_extrema_detector: directed spike frames plus random frames,
// each output cycle compared against a whole-frame reference model.
module tb_dog_extrema_detector;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TH = 3;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int VW = 3 + XW + YW + 9;

  logic iclk = 1'b0;
  logic irst_n, iValid, iSOF;
  logic signed [8:0] iDOG1, iDOG2, iDOG3;
  logic oValid, oKeypoint, oPolarity;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic signed [8:0] oDOG;

  dog_extrema_detector #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONTRAST_TH(TH)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iSOF(iSOF),
    .iDOG1(iDOG1), .iDOG2(iDOG2), .iDOG3(iDOG3),
    .oValid(oValid), .oKeypoint(oKeypoint), .oPolarity(oPolarity),
    .oX(oX), .oY(oY), .oDOG(oDOG)
  );

  always #5 iclk = ~iclk;

  // frame image per scale: f[scale][row][col]
  int f [3][H][W];
  int mx, my;
  logic pv, pkp, ppol;
  int pX, pY, pDog;
  int lastX, lastY, lastDog;
  int nChecks, nPass, nFail;
  int nValid, nKp, expValid, expKp;
  int kpX, kpY, kpPol;
  logic [8:0] kpDog;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 1 = max, -1 = min, 0 = none, straight from the frame image
  function automatic int classify(int cx, int cy);
    int c;
    bit isMax, isMin;
    c = f[1][cy][cx];
    isMax = (c > TH);
    isMin = (c < -TH);
    for (int s = 0; s < 3; s++)
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          if (s == 1 && dy == 0 && dx == 0) continue;
          if (!(c > f[s][cy+dy][cx+dx])) isMax = 0;
          if (!(c < f[s][cy+dy][cx+dx])) isMin = 0;
        end
    return isMax ? 1 : (isMin ? -1 : 0);
  endfunction

  task automatic clearFrame();
    for (int s = 0; s < 3; s++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) f[s][y][x] = 0;
  endtask

  task automatic randFrame();
    for (int s = 0; s < 3; s++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) f[s][y][x] = int'($urandom_range(12)) - 6;
    for (int k = 0; k < 4; k++) begin
      int mag;
      mag = int'($urandom_range(60, 4));
      f[1][$urandom_range(H-1)][$urandom_range(W-1)] = ($urandom_range(1) == 1) ? mag : -mag;
    end
  endtask

  // one clock: drive, advance the model, then compare against the entry
  // produced by the previous step (two-cycle latency in DUT terms)
  task automatic step(bit rstN, bit v, bit sof);
    int px, py, cls;
    logic nv, nkp, npol;
    int nx, ny, ndog;
    logic [VW-1:0] expV, obsV;
    nv = 0; nkp = 0; npol = 0; nx = 0; ny = 0; ndog = 0;
    irst_n = rstN;
    iValid = v;
    iSOF   = sof;
    iDOG1  = 9'($urandom);
    iDOG2  = 9'($urandom);
    iDOG3  = 9'($urandom);
    if (rstN && v) begin
      if (sof) begin mx = 0; my = 0; end
      px = mx; py = my;
      iDOG1 = 9'(f[0][py][px]);
      iDOG2 = 9'(f[1][py][px]);
      iDOG3 = 9'(f[2][py][px]);
      if (px >= 1 && py >= 1) begin
        nv = 1; nx = px - 1; ny = py - 1;
        ndog = f[1][ny][nx];
        cls = (nx >= 1 && ny >= 1) ? classify(nx, ny) : 0;
        nkp = (cls != 0);
        npol = (cls > 0);
        expValid++;
        if (nkp) expKp++;
      end
      mx = px + 1;
      if (mx == W) begin
        mx = 0;
        my = (py + 1 == H) ? 0 : py + 1;
      end
    end
    if (!rstN) begin mx = 0; my = 0; end
    @(posedge iclk);
    #1;
    obsV = {oValid, oKeypoint, oPolarity, oX, oY, oDOG};
    if (!rstN) begin
      expV = '0;
      lastX = 0; lastY = 0; lastDog = 0;
    end else if (pv) begin
      expV = {1'b1, pkp, ppol, XW'(pX), YW'(pY), 9'(pDog)};
      lastX = pX; lastY = pY; lastDog = pDog;
    end else begin
      expV = {3'b000, XW'(lastX), YW'(lastY), 9'(lastDog)};
    end
    check("out", 32'(obsV), 32'(expV));
    if (oValid) nValid++;
    if (oKeypoint) begin
      nKp++; kpX = oX; kpY = oY; kpPol = oPolarity; kpDog = oDOG;
    end
    pv = rstN ? nv : 1'b0;
    pkp = nkp; ppol = npol; pX = nx; pY = ny; pDog = ndog;
  endtask

  task automatic startCounts();
    nValid = 0; nKp = 0; expValid = 0; expKp = 0;
    kpX = -1; kpY = -1; kpPol = -1; kpDog = '0;
  endtask

  task automatic feedFrame(int gapPct, bit useSof);
    startCounts();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        while (int'($urandom_range(99)) < gapPct) step(1, 0, 0);
        step(1, 1, useSof && x == 0 && y == 0);
      end
    step(1, 0, 0);
    step(1, 0, 0);
    check("nValid", nValid, (W-1)*(H-1));
    check("nKp", nKp, expKp);
  endtask

  task automatic checkKp(int x, int y, int pol, logic [8:0] dog);
    check("nKp1", nKp, 1);
    check("kpX", kpX, x);
    check("kpY", kpY, y);
    check("kpPol", kpPol, pol);
    check("kpDog", 32'(kpDog), 32'(dog));
  endtask

  initial begin
    nChecks = 0; nPass = 0; nFail = 0;
    mx = 0; my = 0; pv = 0; pkp = 0; ppol = 0; pX = 0; pY = 0; pDog = 0;
    lastX = 0; lastY = 0; lastDog = 0;
    irst_n = 0; iValid = 0; iSOF = 0; iDOG1 = 0; iDOG2 = 0; iDOG3 = 0;
    startCounts();
    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);

    // flat frame
    clearFrame();
    feedFrame(0, 1);
    check("flatKp", nKp, 0);

    // positive spike
    clearFrame(); f[1][3][3] = 20;
    feedFrame(0, 1);
    checkKp(3, 3, 1, 9'd20);

    // negative spike, then one sitting exactly on the threshold
    clearFrame(); f[1][2][5] = -10;
    feedFrame(0, 1);
    checkKp(5, 2, 0, 9'h1F6);
    clearFrame(); f[1][2][5] = -3;
    feedFrame(0, 0);
    check("thKp", nKp, 0);

    // tie with the scale above, border row, far interior column
    clearFrame(); f[1][3][3] = 20; f[2][3][3] = 20;
    feedFrame(0, 1);
    check("tieKp", nKp, 0);
    clearFrame(); f[1][0][3] = 20;
    feedFrame(0, 1);
    check("borderKp", nKp, 0);
    clearFrame(); f[1][3][6] = 20;
    feedFrame(0, 1);
    checkKp(6, 3, 1, 9'd20);

    // spike with ~50% input gaps
    clearFrame(); f[1][3][3] = 20;
    feedFrame(50, 1);
    checkKp(3, 3, 1, 9'd20);

    // iSOF restart from position (5,2); lone iSOF without iValid is ignored
    randFrame();
    startCounts();
    for (int i = 0; i < 2*W + 5; i++) step(1, 1, 0);
    step(1, 0, 1);
    check("midX", mx, 5);
    step(1, 0, 0);
    step(1, 0, 0);
    clearFrame(); f[1][3][3] = 20;
    feedFrame(0, 1);
    checkKp(3, 3, 1, 9'd20);

    // synchronous reset mid-frame, with a sample offered during reset
    randFrame();
    startCounts();
    for (int i = 0; i < 19; i++) step(1, 1, 0);
    step(0, 1, 0);
    clearFrame(); f[1][3][3] = 20;
    feedFrame(0, 0);
    checkKp(3, 3, 1, 9'd20);

    // random frames with gaps against the reference model
    for (int k = 0; k < 6; k++) begin
      randFrame();
      feedFrame(30, (k % 2) == 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
